// File: rtl/dig_updown_counter_if.sv
// Command/status bundle for the saturating up/down counter stage.
// The upstream control stage drives the commands. The counter stage returns its count and status.
interface dig_updown_counter_if #(
    parameter int WIDTH = 5
);
    logic             EN;
    logic [WIDTH-1:0] IN_VALUE;
    logic             LOAD;
    logic             UP;
    logic             DOWN;
    logic [WIDTH-1:0] COUNTER;
    logic             HIGH;
    logic             LOW;
    logic             BLOCKED;
    logic [1:0]       STATE;

    modport master (
        output EN, IN_VALUE, LOAD, UP, DOWN,
        input  COUNTER, HIGH, LOW, BLOCKED, STATE
    );

    modport slave (
        input  EN, IN_VALUE, LOAD, UP, DOWN,
        output COUNTER, HIGH, LOW, BLOCKED, STATE
    );
endinterface

// File: rtl/dig_updown_counter.sv
// Saturating up/down counter with a load command and boundary status.
// A two-bit direction state records the last action taken: idle/load, up, down or refused.
// In edge mode UP/DOWN count once per rising edge of the request. LOAD stays level-sensitive.
module dig_updown_counter #(
    parameter int WIDTH     = 5,
    parameter bit EDGE_MODE = 1'b0
) (
    input logic               CLK,
    input logic               RST,
    dig_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_SAT  = 2'b11
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic             blocked, blocked_next;
    logic             up_prev, down_prev;
    logic             up_act, down_act;

    // Qualify the requests. In edge mode a request acts only in the cycle it rises.
    always_comb begin
        up_act   = bus.UP;
        down_act = bus.DOWN;
        if (EDGE_MODE) begin
            up_act   = bus.UP & ~up_prev;
            down_act = bus.DOWN & ~down_prev;
        end
    end

    // Next count/state/blocked. The limit checks come first, so +1/-1 never wrap.
    always_comb begin
        count_next   = count;
        state_next   = state;
        blocked_next = 1'b0;
        if (bus.EN) begin
            if (bus.LOAD) begin
                count_next = bus.IN_VALUE;
                state_next = ST_IDLE;
            end else if (down_act) begin
                if (count == '0) begin
                    state_next   = ST_SAT;
                    blocked_next = 1'b1;
                end else begin
                    count_next = count - 1'b1;
                    state_next = ST_DOWN;
                end
            end else if (up_act) begin
                if (count == MAX_VAL) begin
                    state_next   = ST_SAT;
                    blocked_next = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                    state_next = ST_UP;
                end
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // State, count, refusal pulse and edge history. EN=0 freezes the edge history.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count     <= '0;
            state     <= ST_IDLE;
            blocked   <= 1'b0;
            up_prev   <= 1'b0;
            down_prev <= 1'b0;
        end else begin
            count   <= count_next;
            state   <= state_next;
            blocked <= blocked_next;
            if (bus.EN) begin
                up_prev   <= bus.UP;
                down_prev <= bus.DOWN;
            end
        end
    end

    assign bus.COUNTER = count;
    assign bus.HIGH    = (count == MAX_VAL);
    assign bus.LOW     = (count == '0);
    assign bus.BLOCKED = blocked;
    assign bus.STATE   = state;

endmodule

// File: tb/tb_dig_updown_counter.sv
// Bench for dig_updown_counter: a level-mode and an edge-mode instance share one stimulus stream.
// The driver pushes the reference model's expectations into a queue.
// The monitor pops and compares after every clock edge.
module tb_dig_updown_counter;

    localparam int W   = 5;
    localparam int MAX = (1 << W) - 1;

    logic clk;
    logic rst_n;

    dig_updown_counter_if #(.WIDTH(W)) bus_lvl ();
    dig_updown_counter_if #(.WIDTH(W)) bus_edg ();

    dig_updown_counter #(.WIDTH(W), .EDGE_MODE(1'b0)) dut_lvl (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_lvl)
    );

    dig_updown_counter #(.WIDTH(W), .EDGE_MODE(1'b1)) dut_edg (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_edg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int cnt[2];
        int st[2];
        int blk[2];
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: index 0 = level mode, index 1 = edge mode
    int m_cnt[2];
    int m_st[2];
    int m_blk[2];
    bit m_up_prev[2];
    bit m_dn_prev[2];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_st[k] = 0; m_blk[k] = 0;
            m_up_prev[k] = 0; m_dn_prev[k] = 0;
        end
    endfunction

    // The state codes are 0 = idle/load/no request, 1 = counted up, 2 = counted down, 3 = refused at a limit.
    function automatic void model_step(int k, bit en, bit ld, bit u, bit d, int v);
        bit ru, rd;
        if (!en) begin
            m_blk[k] = 0;
            return;
        end
        ru = (k == 1) ? (u && !m_up_prev[k]) : u;
        rd = (k == 1) ? (d && !m_dn_prev[k]) : d;
        m_blk[k] = 0;
        if (ld) begin
            m_cnt[k] = v; m_st[k] = 0;
        end else if (rd) begin
            if (m_cnt[k] == 0) begin m_st[k] = 3; m_blk[k] = 1; end
            else begin m_cnt[k] = m_cnt[k] - 1; m_st[k] = 2; end
        end else if (ru) begin
            if (m_cnt[k] == MAX) begin m_st[k] = 3; m_blk[k] = 1; end
            else begin m_cnt[k] = m_cnt[k] + 1; m_st[k] = 1; end
        end else begin
            m_st[k] = 0;
        end
        m_up_prev[k] = u;
        m_dn_prev[k] = d;
    endfunction

    task automatic step(input bit en, input bit ld, input bit u, input bit d, input int v);
        exp_t e;
        @(negedge clk);
        bus_lvl.EN = en; bus_lvl.LOAD = ld; bus_lvl.UP = u; bus_lvl.DOWN = d;
        bus_lvl.IN_VALUE = v[W-1:0];
        bus_edg.EN = en; bus_edg.LOAD = ld; bus_edg.UP = u; bus_edg.DOWN = d;
        bus_edg.IN_VALUE = v[W-1:0];
        for (int k = 0; k < 2; k++) begin
            model_step(k, en, ld, u, d, v);
            e.cnt[k] = m_cnt[k];
            e.st[k]  = m_st[k];
            e.blk[k] = m_blk[k];
        end
        q.push_back(e);
    endtask

    task automatic check_reset_state();
        check("rst_cnt_lvl",  int'(bus_lvl.COUNTER), 0);
        check("rst_low_lvl",  int'(bus_lvl.LOW), 1);
        check("rst_high_lvl", int'(bus_lvl.HIGH), 0);
        check("rst_st_lvl",   int'(bus_lvl.STATE), 0);
        check("rst_blk_lvl",  int'(bus_lvl.BLOCKED), 0);
        check("rst_cnt_edg",  int'(bus_edg.COUNTER), 0);
        check("rst_low_edg",  int'(bus_edg.LOW), 1);
        check("rst_st_edg",   int'(bus_edg.STATE), 0);
    endtask

    // Monitor: compare each registered result just after the edge that produced it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cnt_lvl",  int'(bus_lvl.COUNTER), e.cnt[0]);
                check("st_lvl",   int'(bus_lvl.STATE),   e.st[0]);
                check("blk_lvl",  int'(bus_lvl.BLOCKED), e.blk[0]);
                check("high_lvl", int'(bus_lvl.HIGH),    int'(e.cnt[0] == MAX));
                check("low_lvl",  int'(bus_lvl.LOW),     int'(e.cnt[0] == 0));
                check("cnt_edg",  int'(bus_edg.COUNTER), e.cnt[1]);
                check("st_edg",   int'(bus_edg.STATE),   e.st[1]);
                check("blk_edg",  int'(bus_edg.BLOCKED), e.blk[1]);
                check("high_edg", int'(bus_edg.HIGH),    int'(e.cnt[1] == MAX));
                check("low_edg",  int'(bus_edg.LOW),     int'(e.cnt[1] == 0));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int v;
        rst_n = 1'b0;
        bus_lvl.EN = 0; bus_lvl.LOAD = 0; bus_lvl.UP = 0; bus_lvl.DOWN = 0; bus_lvl.IN_VALUE = '0;
        bus_edg.EN = 0; bus_edg.LOAD = 0; bus_edg.UP = 0; bus_edg.DOWN = 0; bus_edg.IN_VALUE = '0;
        model_reset();
        #3;
        check_reset_state();
        #4 rst_n = 1'b1;

        // Asynchronous reset in the middle of a count
        step(1, 1, 0, 0, 13);
        @(posedge clk);
        #2;
        check("pre_rst_cnt", int'(bus_lvl.COUNTER), 13);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        #1 rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Load near the top, then count into saturation
        step(1, 1, 0, 0, 29);
        repeat (4) step(1, 0, 1, 0, 0);

        // Load near the bottom, then count down to the floor
        step(1, 1, 0, 0, 2);
        repeat (3) step(1, 0, 0, 1, 0);

        // Priority: LOAD over DOWN over UP
        step(1, 1, 0, 0, 10);
        step(1, 1, 1, 1, 7);
        step(1, 0, 1, 1, 0);

        // Enable gating
        step(1, 1, 0, 0, 5);
        repeat (3) step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);

        // Held UP vs re-asserted UP
        step(1, 1, 0, 0, 0);
        repeat (5) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);

        // Randomized traffic, biased toward the limits
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: v = 0;
                1: v = MAX;
                2: v = MAX - 1;
                default: v = $urandom_range(0, MAX);
            endcase
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 v);
        end

        step(1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
